// File: rtl/crg_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crg_uart_pkg
// Description : Shared definitions for the UART receive path. It holds the
//               receiver FSM state encoding, the default clock and baud
//               constants, and the clocks-per-bit helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package crg_uart_pkg;

   localparam int unsigned DEF_CLK_FREQ = 100_000_000;
   localparam int unsigned DEF_BAUD     = 115_200;

   // Receiver FSM states. ST_PARITY is only reachable in parity builds.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } uart_state_e;

   // Clocks per serial bit (integer division, 868 at the defaults).
   function automatic int unsigned calc_cpb(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO. o_data presents the oldest
//               entry while o_valid is high (zero when empty). A push while
//               full is accepted only if a pop happens in the same cycle;
//               otherwise it is dropped and o_drop pulses for that cycle.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_push/i_data - write request and data
//               i_pop         - read accept (ignored while empty)
//               o_data        - head-of-FIFO entry
//               o_valid       - FIFO non-empty
//               o_drop        - push discarded because FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_drop
);

   localparam int unsigned c_AW = $clog2(DEPTH);

   // One extra pointer bit separates the full and empty cases.
   logic [c_AW:0]    r_wr_ptr;
   logic [c_AW:0]    r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                      (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_do_pop  = i_pop && !w_empty;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign w_do_push = i_push && (!w_full || w_do_pop);
   assign o_drop    = i_push && w_full && !w_do_pop;

   assign o_valid = !w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: o_data is forced to zero while empty.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver (8 data bits, LSB first, 1 stop bit) with a
//               two-flop input synchronizer, mid-bit sampling FSM and a
//               show-ahead receive FIFO (sync_fifo).
//               Build option: define UART_RX_PARITY_EN for an even-parity
//               bit between the data and stop bits (8E1). Without it the
//               frame is 8N1 and parity_err is tied low.
// Ports       : clk        - system clock
//               rst        - synchronous active-high reset
//               rxd        - asynchronous serial input, idles high
//               rx_data    - head-of-FIFO byte (valid while rx_valid)
//               rx_valid   - FIFO non-empty
//               rx_ready   - consumer accept, pops when rx_valid is high
//               frame_err  - one-cycle pulse on a bad stop bit
//               parity_err - one-cycle pulse on a parity mismatch
//               overflow   - sticky, a byte was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
   import crg_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
   parameter int unsigned BAUD       = DEF_BAUD,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overflow
);

   localparam int unsigned c_CPB   = calc_cpb(CLK_FREQ, BAUD);
   localparam int unsigned c_CNT_W = $clog2(c_CPB + 1);

   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_CPB);
   localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_CPB / 2);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   localparam logic [2:0] c_S_IDLE   = ST_IDLE;
   localparam logic [2:0] c_S_START  = ST_START;
   localparam logic [2:0] c_S_DATA   = ST_DATA;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] c_S_PARITY = ST_PARITY;
`endif
   localparam logic [2:0] c_S_STOP   = ST_STOP;
   localparam logic [2:0] c_S_WAIT   = ST_WAIT_IDLE;

   logic               r_sync1;
   logic               r_sync2;
   logic               r_rxd_prev;
   logic [2:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_frame_err;
   logic               r_overflow;
`ifdef UART_RX_PARITY_EN
   logic               r_par_bad;
   logic               r_parity_err;
`endif

   logic w_fall;
   logic w_expire;
   logic w_push;
   logic w_drop;

   // ------------------------------------------------------------------
   // Input synchronizer plus one history flop for falling-edge detect.
   // All reset to the idle level so reset never looks like a start bit.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_rxd_prev <= 1'b1;
      end else begin
         r_sync1    <= rxd;
         r_sync2    <= r_sync1;
         r_rxd_prev <= r_sync2;
      end
   end

   assign w_fall = r_rxd_prev && !r_sync2;

   // The counter is loaded with N and the sample is taken on the cycle
   // it reads 1, so successive samples are exactly N clocks apart.
   assign w_expire = (r_cnt == c_CNT_ONE);

`ifdef UART_RX_PARITY_EN
   assign w_push = (r_state == c_S_STOP) && w_expire && r_sync2 && !r_par_bad;
`else
   assign w_push = (r_state == c_S_STOP) && w_expire && r_sync2;
`endif

   // ------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         // Free-running countdown in the timed states; reloads below win.
         if ((r_state != c_S_IDLE) && (r_state != c_S_WAIT) && !w_expire)
            r_cnt <= r_cnt - c_CNT_ONE;

         case (r_state)
            c_S_IDLE: begin
               if (w_fall) begin
                  r_state <= c_S_START;
                  r_cnt   <= c_CNT_HALF;
               end
            end
            c_S_START: begin
               if (w_expire) begin
                  // Still low at mid start bit: real frame, else a glitch.
                  if (!r_sync2) begin
                     r_state   <= c_S_DATA;
                     r_cnt     <= c_CNT_FULL;
                     r_bit_idx <= '0;
                  end else begin
                     r_state <= c_S_IDLE;
                  end
               end
            end
            c_S_DATA: begin
               if (w_expire) begin
                  r_shift   <= {r_sync2, r_shift[7:1]};
                  r_cnt     <= c_CNT_FULL;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     r_state <= c_S_PARITY;
`else
                     r_state <= c_S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            c_S_PARITY: begin
               if (w_expire) begin
                  // Even parity: data ones plus parity bit must be even.
                  r_par_bad <= (^r_shift) ^ r_sync2;
                  r_cnt     <= c_CNT_FULL;
                  r_state   <= c_S_STOP;
               end
            end
`endif
            c_S_STOP: begin
               if (w_expire) begin
                  if (r_sync2) begin
`ifdef UART_RX_PARITY_EN
                     r_parity_err <= r_par_bad;
`endif
                     r_state <= c_S_IDLE;
                  end else begin
                     // A bad stop bit masks any parity result.
                     r_frame_err <= 1'b1;
                     r_state     <= c_S_WAIT;
                  end
               end
            end
            c_S_WAIT: begin
               // Hold off while the line stays low (break) so it cannot
               // be mistaken for a run of zero bytes.
               if (r_sync2) r_state <= c_S_IDLE;
            end
            default: begin
               r_state <= c_S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Receive FIFO and sticky overflow
   // ------------------------------------------------------------------
   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (r_shift),
      .i_pop   (rx_ready),
      .o_data  (rx_data),
      .o_valid (rx_valid),
      .o_drop  (w_drop)
   );

   always_ff @(posedge clk) begin
      if (rst) r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
   end

   assign frame_err = r_frame_err;
   assign overflow  = r_overflow;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, sets the input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, sets the serial bit rate; CPB = CLK_FREQ/BAUD with integer division (868 at defaults).
REQ-003 Parameter FIFO_DEPTH, default 16, sets the receive FIFO entry count (power of 2, >=2).
REQ-004 Port clk, input, 1, the single system clock.
REQ-005 Port rst, input, 1, reset: synchronous, active-high.
REQ-006 Port rxd, input, 1, asynchronous serial line from the board UART bridge; idles high.
REQ-007 Port rx_data, output, 8, head-of-FIFO byte; valid only while rx_valid=1.
REQ-008 Port rx_valid, output, 1, asserted while the FIFO is non-empty.
REQ-009 Port rx_ready, input, 1, consumer accept; a pop occurs on a cycle where rx_valid and rx_ready are both 1.
REQ-010 Port frame_err, output, 1, one-cycle pulse when a bad stop bit is detected.
REQ-011 Port parity_err, output, 1, one-cycle pulse when a parity mismatch is detected.
REQ-012 Port overflow, output, 1, sticky flag set when a received byte is dropped because the FIFO is full.

Function
REQ-013 rxd shall pass through a two-flop synchronizer before use; both flops reset to 1.
REQ-014 FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE.
REQ-015 IDLE->START on a synchronized 1->0 transition of rxd; the bit counter loads CPB/2.
REQ-016 START re-samples rxd when the counter expires: 0 -> DATA with counter = CPB; 1 -> IDLE (glitch rejected, no output).
REQ-017 DATA samples 8 bits LSB-first, one sample every CPB cycles, into a shift register, then moves to PARITY (macro on) or STOP.
REQ-018 STOP samples rxd after CPB cycles: 1 -> push the byte to the FIFO and return to IDLE; 0 -> pulse frame_err, discard the byte, go to WAIT_IDLE.
REQ-019 WAIT_IDLE shall stay until synchronized rxd=1, then go to IDLE; this prevents a held-low line (break) from producing bytes.
REQ-020 Push latency: rx_valid shall assert on the cycle after the STOP sample cycle when the FIFO was empty; there is no same-cycle fall-through.
REQ-021 FIFO is show-ahead: rx_data shall present the oldest byte whenever rx_valid=1 and stay stable until popped.
REQ-022 Push while full without a same-cycle pop: drop the byte, set overflow, leave FIFO contents unchanged.
REQ-023 Push while full with a same-cycle pop: accept both; no overflow.
REQ-024 Pop while empty: no effect (rx_ready is ignored while rx_valid=0).
REQ-025 FIFO read/write pointers shall be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; the extra MSB distinguishes full from empty.
REQ-026 overflow shall clear only on rst.

Reset
REQ-027 On rst=1 at a clk edge: FSM->IDLE, counters 0, FIFO empty, rx_valid=0, rx_data=0, frame_err=0, parity_err=0, overflow=0.
REQ-028 A reset asserted mid-frame shall abandon the partial byte; reception resumes at the next falling edge seen after reset is released.

Configuration
REQ-029 Macro UART_RX_PARITY_EN: when defined, an even-parity bit follows the data bits and is sampled in PARITY after CPB cycles.
REQ-030 With UART_RX_PARITY_EN, a parity mismatch shall pulse parity_err and discard the byte; the STOP check still runs, and frame_err takes precedence (only frame_err pulses if both fail).
REQ-031 Without UART_RX_PARITY_EN: the PARITY state is absent, the frame is 8N1, and parity_err is tied to 0.

Structure
REQ-032 Shared package crg_uart_pkg shall hold the FSM state enum, the default CLK_FREQ and BAUD constants, and a function computing CPB.
REQ-033 The FIFO shall be a separate sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated once; the FSM, synchronizer and counters live in uart_rx.

Verification
REQ-034 8N1 frame 0xA5 at 115200 with rx_ready=1 -> one cycle of rx_valid with rx_data=0xA5; frame_err=0.
REQ-035 Low pulse of 300 cycles on idle rxd -> no push, rx_valid stays 0, FSM back in IDLE.
REQ-036 Frame 0x3C with stop bit 0, then rxd held low for 20 bit times, then released -> single frame_err pulse, no byte output, next frame 0x55 received correctly.
REQ-037 rx_ready=0, 17 frames 0x00..0x10 at FIFO_DEPTH=16 -> overflow=1; popping returns 0x00..0x0F in order; 0x10 is absent.
REQ-038 FIFO full, with a pop in the same cycle as the 17th push -> overflow stays 0; 16 entries remain.
REQ-039 With UART_RX_PARITY_EN: byte 0x01 with parity bit 0 -> parity_err pulse, no push; byte 0x03 with parity bit 0 -> rx_data=0x03.
